// File: rtl/riscv_rf_mp.sv
// riscv_rf_mp: N-read / M-write integer register file with a post-reset clear
// sweep, optional write-to-read bypass and a registered debug access path.
//
// state | meaning
// CLEAR | zeroing x1..x(NREGS-1), one per cycle; writes ignored, outputs 0
// RUN   | normal operation, rf_ready high
module riscv_rf_mp #(
  parameter int XLEN    = 64,
  parameter int AR_BITS = 5,
  parameter int NREGS   = 32,
  parameter int RDPORTS = 2,
  parameter int WRPORTS = 1,
  parameter int BYPASS  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rf_ready,
  input  logic [RDPORTS*AR_BITS-1:0] rf_src1,
  input  logic [RDPORTS*AR_BITS-1:0] rf_src2,
  output logic [RDPORTS*XLEN-1:0]    rf_srcv1,
  output logic [RDPORTS*XLEN-1:0]    rf_srcv2,
  input  logic [WRPORTS*AR_BITS-1:0] rf_dst,
  input  logic [WRPORTS*XLEN-1:0]    rf_dstv,
  input  logic [WRPORTS-1:0]         rf_we,
  input  logic                       du_stall,
  input  logic                       du_we_rf,
  input  logic                       du_re_rf,
  input  logic [11:0]                du_addr,
  input  logic [XLEN-1:0]            du_dato,
  output logic [XLEN-1:0]            du_dati_rf
);

  localparam int DEPTH = 1 << AR_BITS;
  localparam logic [AR_BITS:0]   NREGS_W  = (AR_BITS+1)'(NREGS);
  localparam logic [AR_BITS-1:0] LAST_PTR = AR_BITS'(NREGS - 1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                    state_q, state_d;
  logic [AR_BITS-1:0]        clr_ptr_q, clr_ptr_d;
  logic [XLEN-1:0]           regs_q [DEPTH];
  logic [XLEN-1:0]           regs_d [DEPTH];
  logic [XLEN-1:0]           rd_view [DEPTH];
  logic [RDPORTS*XLEN-1:0]   srcv1_q, srcv1_d, srcv2_q, srcv2_d;
  logic [XLEN-1:0]           dati_q, dati_d;
  logic                      ready_q, ready_d;
  logic                      du_wr, du_rd;
  logic [AR_BITS-1:0]        du_reg;
  logic [AR_BITS-1:0]        a1, a2, aw;
  logic                      unused_du_addr;

  assign unused_du_addr = ^du_addr[11:AR_BITS];

  // x0 is hardwired and addresses past NREGS do not exist
  function automatic logic addr_ok(input logic [AR_BITS-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_W);
  endfunction

  always_comb begin
    du_reg    = du_addr[AR_BITS-1:0];
    du_wr     = du_we_rf && du_stall;
    du_rd     = du_re_rf && du_stall;
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    aw        = '0;
    a1        = '0;
    a2        = '0;
    regs_d    = regs_q;

    if (state_q == CLEAR) begin
      regs_d[clr_ptr_q] = '0;
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LAST_PTR) state_d = RUN;
    end else if (!rst) begin
      // ascending order so the highest port, then debug, wins a shared address
      for (int w = 0; w < WRPORTS; w++) begin
        aw = rf_dst[w*AR_BITS +: AR_BITS];
        if (rf_we[w] && addr_ok(aw)) regs_d[aw] = rf_dstv[w*XLEN +: XLEN];
      end
      if (du_wr && addr_ok(du_reg)) regs_d[du_reg] = du_dato;
    end

    for (int i = 0; i < DEPTH; i++)
      rd_view[i] = (BYPASS != 0) ? regs_d[i] : regs_q[i];

    srcv1_d = '0;
    srcv2_d = '0;
    dati_d  = dati_q;
    if (state_q == RUN) begin
      for (int p = 0; p < RDPORTS; p++) begin
        a1 = rf_src1[p*AR_BITS +: AR_BITS];
        a2 = rf_src2[p*AR_BITS +: AR_BITS];
        srcv1_d[p*XLEN +: XLEN] = addr_ok(a1) ? rd_view[a1] : '0;
        srcv2_d[p*XLEN +: XLEN] = addr_ok(a2) ? rd_view[a2] : '0;
      end
      if (du_rd) dati_d = addr_ok(du_reg) ? rd_view[du_reg] : '0;
    end else begin
      dati_d = '0;
    end

    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= AR_BITS'(1);
      srcv1_q   <= '0;
      srcv2_q   <= '0;
      dati_q    <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      srcv1_q   <= srcv1_d;
      srcv2_q   <= srcv2_d;
      dati_q    <= dati_d;
      ready_q   <= ready_d;
    end
  end

  assign rf_ready   = ready_q;
  assign rf_srcv1   = srcv1_q;
  assign rf_srcv2   = srcv2_q;
  assign du_dati_rf = dati_q;

endmodule
